// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: two-requester round-robin arbiter in front of one single-port
// valid/ready memory, with a per-access timeout that completes a hung access with err.
`default_nettype none

module mem_port_arbiter #(
  parameter int WIDTH   = 32,
  parameter int ADDRE   = 8,
  parameter int TIMEOUT = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             req0_valid_i,
  input  logic             req0_wrdata_i,
  input  logic [ADDRE-1:0] req0_addre_i,
  input  logic [WIDTH-1:0] req0_write_i,
  output logic             req0_ready_o,
  output logic             req0_err_o,
  input  logic             req1_valid_i,
  input  logic             req1_wrdata_i,
  input  logic [ADDRE-1:0] req1_addre_i,
  input  logic [WIDTH-1:0] req1_write_i,
  output logic             req1_ready_o,
  output logic             req1_err_o,
  output logic [WIDTH-1:0] rsp_read_o,
  output logic             mem_valid_o,
  output logic             mem_wrdata_o,
  output logic [ADDRE-1:0] mem_addre_o,
  output logic [WIDTH-1:0] mem_write_o,
  input  logic             mem_ready_i,
  input  logic [WIDTH-1:0] mem_read_i,
  output logic             busy_o,
  output logic             grant_o
);

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state, state_nxt;
  logic            prio;       // requester that wins a tie in IDLE
  logic            err_flag;
  logic [CW-1:0]   count;
  logic            take;
  logic            sel;
  logic            timeout_hit;

  assign timeout_hit = (count == CW'(TIMEOUT - 1));

  always_ff @(posedge clk_i) begin
    if (!rst_i) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    take      = 1'b0;
    sel       = 1'b0;
    unique case (state)
      IDLE: begin
        if (req0_valid_i && req1_valid_i) begin
          take = 1'b1;
          sel  = prio;
        end else if (req0_valid_i) begin
          take = 1'b1;
          sel  = 1'b0;
        end else if (req1_valid_i) begin
          take = 1'b1;
          sel  = 1'b1;
        end
        if (take) state_nxt = BUSY;
      end
      BUSY:    if (mem_ready_i || timeout_hit) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      prio         <= 1'b0;
      grant_o      <= 1'b0;
      err_flag     <= 1'b0;
      count        <= '0;
      rsp_read_o   <= '0;
      mem_wrdata_o <= 1'b0;
      mem_addre_o  <= '0;
      mem_write_o  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          count    <= '0;
          err_flag <= 1'b0;
          if (take) begin
            grant_o      <= sel;
            mem_wrdata_o <= sel ? req1_wrdata_i : req0_wrdata_i;
            mem_addre_o  <= sel ? req1_addre_i  : req0_addre_i;
            mem_write_o  <= sel ? req1_write_i  : req0_write_i;
          end
        end
        BUSY: begin
          count <= count + 1'b1;
          // Ready beats a coinciding timeout.
          if (mem_ready_i) begin
            if (!mem_wrdata_o) rsp_read_o <= mem_read_i;
          end else if (timeout_hit) begin
            err_flag <= 1'b1;
          end
        end
        DONE: begin
          prio     <= ~grant_o;
          count    <= '0;
          err_flag <= 1'b0;
        end
        default: begin
          count    <= '0;
          err_flag <= 1'b0;
        end
      endcase
    end
  end

  assign mem_valid_o  = (state == BUSY);
  assign busy_o       = (state != IDLE);
  assign req0_ready_o = (state == DONE) && !grant_o;
  assign req1_ready_o = (state == DONE) &&  grant_o;
  assign req0_err_o   = req0_ready_o && err_flag;
  assign req1_err_o   = req1_ready_o && err_flag;

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed bench with a small latency-programmable memory responder.
`default_nettype none

module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        v [2];
  logic        w [2];
  logic [7:0]  a [2];
  logic [31:0] d [2];
  logic        rdy0, rdy1, err0, err1;
  logic [31:0] rsp_read;
  logic        mem_valid, mem_wr;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ready = 1'b0;
  logic [31:0] mem_rdata = 32'h0;
  logic        busy, grant;

  logic [31:0] mem [256];
  int          mem_lat = 1;   // ready in this BUSY cycle (1-based); 0 = never
  int          bcnt = 0;
  int          total = 0;
  int          bad = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.WIDTH(32), .ADDRE(8), .TIMEOUT(16)) dut (
    .clk_i(clk), .rst_i(rst),
    .req0_valid_i(v[0]), .req0_wrdata_i(w[0]), .req0_addre_i(a[0]), .req0_write_i(d[0]),
    .req0_ready_o(rdy0), .req0_err_o(err0),
    .req1_valid_i(v[1]), .req1_wrdata_i(w[1]), .req1_addre_i(a[1]), .req1_write_i(d[1]),
    .req1_ready_o(rdy1), .req1_err_o(err1),
    .rsp_read_o(rsp_read),
    .mem_valid_o(mem_valid), .mem_wrdata_o(mem_wr), .mem_addre_o(mem_addr),
    .mem_write_o(mem_wdata), .mem_ready_i(mem_ready), .mem_read_i(mem_rdata),
    .busy_o(busy), .grant_o(grant)
  );

  always @(negedge clk) begin
    if (!rst || !mem_valid) begin
      bcnt      <= 0;
      mem_ready <= 1'b0;
    end else begin
      bcnt      <= bcnt + 1;
      mem_ready <= (bcnt + 1 == mem_lat);
      mem_rdata <= mem[mem_addr];
      if (bcnt + 1 == mem_lat && mem_wr) mem[mem_addr] <= mem_wdata;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rst  = 1'b0;
    v[0] = 1'b0;
    v[1] = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  // One access from requester p; returns rsp_read_o seen with the ready pulse.
  task automatic access(input int p, input logic wr, input logic [7:0] addr,
                        input logic [31:0] data, input int lat, input int exp_cyc,
                        input logic exp_err, output logic [31:0] rd);
    int  c;
    logic r, e, ro, eo;
    mem_lat = lat;
    w[p] = wr;
    a[p] = addr;
    d[p] = data;
    v[p] = 1'b1;
    c = 0;
    r = 1'b0;
    while (!r && c < 100) begin
      @(posedge clk);
      #1 c++;
      r = (p == 0) ? rdy0 : rdy1;
      if (c == 1) begin
        check("busy_mem_valid", mem_valid, 1'b1);
        check("busy_mem_addr", mem_addr, addr);
        check("busy_mem_wr", mem_wr, wr);
        check("busy_mem_wdata", mem_wdata, data);
        check("busy_grant", grant, p[0]);
        check("busy_flag", busy, 1'b1);
      end
    end
    e  = (p == 0) ? err0 : err1;
    ro = (p == 0) ? rdy1 : rdy0;
    eo = (p == 0) ? err1 : err0;
    check("ready_seen", r, 1'b1);
    check("ready_cycles", c, exp_cyc);
    check("err", e, exp_err);
    check("other_ready", ro, 1'b0);
    check("other_err", eo, 1'b0);
    rd = rsp_read;
    v[p] = 1'b0;
    @(posedge clk);
    #1 r = (p == 0) ? rdy0 : rdy1;
    check("ready_one_pulse", r, 1'b0);
  endtask

  initial begin
    logic [31:0] rd, dat;
    int c, expg;
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    v[0] = 0; v[1] = 0; w[0] = 0; w[1] = 0;
    a[0] = 0; a[1] = 0; d[0] = 0; d[1] = 0;

    do_reset();
    check("rst_ready0", rdy0, 1'b0);
    check("rst_ready1", rdy1, 1'b0);
    check("rst_err", {err0, err1}, 2'b00);
    check("rst_mem_valid", mem_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_grant", grant, 1'b0);
    check("rst_rsp", rsp_read, 32'h0);
    check("rst_mem_bus", {mem_wr, mem_addr, mem_wdata}, 41'h0);

    // Write then read, requester 0, memory ready in 2nd BUSY cycle.
    access(0, 1'b1, 8'h05, 32'hDEADBEEF, 2, 3, 1'b0, rd);
    check("write_keeps_rsp", rd, 32'h0);
    access(0, 1'b0, 8'h05, 32'h0, 2, 3, 1'b0, rd);
    check("read_back", rd, 32'hDEADBEEF);

    // Contention from reset: grants alternate 0,1,0,1.
    do_reset();
    mem_lat = 1;
    w[0] = 1; a[0] = 8'h10; d[0] = 32'h1;
    w[1] = 1; a[1] = 8'h20; d[1] = 32'h2;
    v[0] = 1; v[1] = 1;
    expg = 0;
    for (int n = 0; n < 4; n++) begin
      c = 0;
      do begin
        @(posedge clk);
        #1 c++;
      end while (!(rdy0 || rdy1) && c < 50);
      check("cont_rdy0", rdy0, expg == 0);
      check("cont_rdy1", rdy1, expg == 1);
      check("cont_grant", grant, expg[0]);
      check("cont_gap", c, (n == 0) ? 2 : 3);
      expg ^= 1;
    end
    v[0] = 0; v[1] = 0;
    repeat (2) @(posedge clk);
    #1;

    // Timeout: rsp_read_o keeps the previous read value.
    access(1, 1'b0, 8'hFF, 32'h0, 0, 17, 1'b1, rd);
    check("timeout_rsp_kept", rd, 32'h0);
    access(0, 1'b0, 8'h05, 32'h0, 1, 2, 1'b0, rd);
    check("after_timeout_read", rd, 32'hDEADBEEF);
    access(0, 1'b1, 8'h33, 32'hCAFEF00D, 1, 2, 1'b0, rd);
    // Ready on the last allowed BUSY cycle.
    access(1, 1'b0, 8'h33, 32'h0, 16, 17, 1'b0, rd);
    check("last_cycle_read", rd, 32'hCAFEF00D);

    // Reset in the middle of a hung access.
    mem_lat = 0;
    w[0] = 0; a[0] = 8'h03; v[0] = 1;
    repeat (3) @(posedge clk);
    #1 check("mid_busy", busy, 1'b1);
    rst = 0;
    @(posedge clk);
    #1;
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_mem_valid", mem_valid, 1'b0);
    check("mid_rst_ready", {rdy0, rdy1, err0, err1}, 4'h0);
    check("mid_rst_rsp", rsp_read, 32'h0);
    v[0] = 0;
    rst = 1;
    access(1, 1'b0, 8'h05, 32'h0, 1, 2, 1'b0, rd);
    check("post_rst_read", rd, 32'hDEADBEEF);

    // Sweep: req0 writes every address, req1 reads it back.
    for (int i = 0; i < 256; i++) begin
      dat = $urandom;
      access(0, 1'b1, i[7:0], dat, (i % 3) + 1, (i % 3) + 2, 1'b0, rd);
      access(1, 1'b0, i[7:0], $urandom, 1, 2, 1'b0, rd);
      check("sweep_read", rd, dat);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
